// File: rtl/fd_pkg.sv
// Shared definitions for the FAST-9 frame path: image geometry, SRAM address
// width, pixel width and the loader state encoding. Also used by the detector
// controller and the address calculator, so edit with care.
package fd_pkg;

  // Loader phases: waiting for start-of-frame, loading pixels, frame held.
  typedef enum logic [1:0] {
    FD_IDLE = 2'd0,
    FD_LOAD = 2'd1,
    FD_DONE = 2'd2
  } fd_state_e;

  localparam int FD_IMG_W  = 128;
  localparam int FD_IMG_H  = 128;
  localparam int FD_ADDR_W = 15;
  localparam int FD_PIX_W  = 8;
  localparam int FD_NPIX   = FD_IMG_W * FD_IMG_H;

endpackage

// File: rtl/fd_wr_port.sv
// Registered SRAM write stage. Captures one accepted pixel per cycle and
// presents address/data/enable to the SRAM on the following cycle. Reset
// clears the stage, which also drops a write captured on the reset edge.
module fd_wr_port
  import fd_pkg::*;
#(
  parameter int ADDR_W = FD_ADDR_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [FD_PIX_W-1:0] wr_data,
  output logic [ADDR_W-1:0]   sramAddr,
  output logic [FD_PIX_W-1:0] sramData,
  output logic                sramWren
);

  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [FD_PIX_W-1:0] data_q, data_d;
  logic                wren_q, wren_d;

  // Next write: load address/data on an accepted pixel, otherwise hold them.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    wren_d = wr_en;
    if (wr_en) begin
      addr_d = wr_addr;
      data_d = wr_data;
    end
  end

  // Write-stage registers; reset suppresses any pending write.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
      wren_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      wren_q <= wren_d;
    end
  end

  assign sramAddr = addr_q;
  assign sramData = data_q;
  assign sramWren = wren_q;

endmodule

// File: rtl/fd_frame_loader.sv
// Write-side front end of the FAST-9 image SRAM. Accepts a raster pixel
// stream, writes each pixel at its linear address (an incrementing counter,
// no multiplier), then holds the frame with frameReady until the detector
// controller acknowledges it. Framing problems are reported on sticky flags.
module fd_frame_loader
  import fd_pkg::*;
#(
  parameter int WIDTH  = FD_IMG_W,
  parameter int HEIGHT = FD_IMG_H,
  parameter int ADDR_W = FD_ADDR_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pixValid,
  output logic                pixReady,
  input  logic [FD_PIX_W-1:0] pixData,
  input  logic                pixSof,
  input  logic                pixEof,
  output logic [ADDR_W-1:0]   sramAddr,
  output logic [FD_PIX_W-1:0] sramData,
  output logic                sramWren,
  output logic                frameReady,
  input  logic                detAck,
  output logic [7:0]          frameCount,
  output logic                errShort,
  output logic                errSync,
  output logic                errLong
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

  localparam logic [1:0] ST_IDLE = FD_IDLE;
  localparam logic [1:0] ST_LOAD = FD_LOAD;
  localparam logic [1:0] ST_DONE = FD_DONE;

  // The whole frame must be addressable and the geometry non-degenerate.
  if ((WIDTH < 2) || (HEIGHT < 2) ||
      (longint'(NPIX) > (longint'(1) << ADDR_W))) begin : g_geom_bad
    $error("fd_frame_loader: WIDTH*HEIGHT does not fit in ADDR_W or dimension < 2");
  end

  logic [1:0]          state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                frame_ready_q, frame_ready_d;
  logic [7:0]          frame_count_q, frame_count_d;
  logic                err_short_q, err_short_d;
  logic                err_sync_q, err_sync_d;
  logic                err_long_q, err_long_d;

  logic                accept;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [FD_PIX_W-1:0] wr_data;

  assign accept = pixValid & ready_q;

  // Frame FSM: start detection, pixel counting, completion and hand-off.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    frame_ready_d = frame_ready_q;
    frame_count_d = frame_count_q;
    err_short_d   = err_short_q;
    err_sync_d    = err_sync_q;
    err_long_d    = err_long_q;
    wr_en         = 1'b0;
    wr_addr       = cnt_q;
    wr_data       = pixData;

    case (state_q)
      ST_IDLE: begin
        // Pixels before a start-of-frame are consumed and discarded.
        if (accept && pixSof) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          if (pixEof) begin
            err_short_d = 1'b1;
            cnt_d       = '0;
          end else begin
            cnt_d   = ONE_ADDR;
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          if (pixSof) begin
            // Unexpected restart: treat as the first pixel of a new frame.
            err_sync_d = 1'b1;
            wr_addr    = '0;
            if (pixEof) begin
              err_short_d = 1'b1;
              cnt_d       = '0;
              state_d     = ST_IDLE;
            end else begin
              cnt_d = ONE_ADDR;
            end
          end else if (cnt_q == LAST_ADDR) begin
            // Last pixel completes the frame whether or not it carries EOF.
            if (!pixEof) begin
              err_long_d = 1'b1;
            end
            cnt_d   = '0;
            state_d = ST_DONE;
          end else if (pixEof) begin
            err_short_d = 1'b1;
            cnt_d       = '0;
            state_d     = ST_IDLE;
          end else begin
            cnt_d = cnt_q + ONE_ADDR;
          end
        end
      end

      ST_DONE: begin
        // First DONE cycle is the last write's SRAM cycle; publish after it.
        if (!frame_ready_q) begin
          frame_ready_d = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
        end else if (detAck) begin
          frame_ready_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Input is held off for as long as a frame sits in the SRAM.
    ready_d = (state_d != ST_DONE);
  end

  // Control registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      ready_q       <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_count_q <= 8'd0;
      err_short_q   <= 1'b0;
      err_sync_q    <= 1'b0;
      err_long_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ready_q       <= ready_d;
      frame_ready_q <= frame_ready_d;
      frame_count_q <= frame_count_d;
      err_short_q   <= err_short_d;
      err_sync_q    <= err_sync_d;
      err_long_q    <= err_long_d;
    end
  end

  fd_wr_port #(
    .ADDR_W (ADDR_W)
  ) u_wr_port (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .sramAddr (sramAddr),
    .sramData (sramData),
    .sramWren (sramWren)
  );

  assign pixReady   = ready_q;
  assign frameReady = frame_ready_q;
  assign frameCount = frame_count_q;
  assign errShort   = err_short_q;
  assign errSync    = err_sync_q;
  assign errLong    = err_long_q;

endmodule

// File: tb/tb_fd_frame_loader.sv
// Bench for fd_frame_loader on a 64x64 frame: randomized valid gaps and data,
// a frame-level reference model compared every cycle, and literal checks.
module tb_fd_frame_loader;

  localparam int W    = 64;
  localparam int H    = 64;
  localparam int AW   = 15;
  localparam int NPIX = W * H;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          pixValid = 1'b0;
  logic          pixReady;
  logic [7:0]    pixData = 8'd0;
  logic          pixSof = 1'b0;
  logic          pixEof = 1'b0;
  logic [AW-1:0] sramAddr;
  logic [7:0]    sramData;
  logic          sramWren;
  logic          frameReady;
  logic          detAck = 1'b0;
  logic [7:0]    frameCount;
  logic          errShort, errSync, errLong;

  fd_frame_loader #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .pixValid   (pixValid),
    .pixReady   (pixReady),
    .pixData    (pixData),
    .pixSof     (pixSof),
    .pixEof     (pixEof),
    .sramAddr   (sramAddr),
    .sramData   (sramData),
    .sramWren   (sramWren),
    .frameReady (frameReady),
    .detAck     (detAck),
    .frameCount (frameCount),
    .errShort   (errShort),
    .errSync    (errSync),
    .errLong    (errLong)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int wcnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge.
  logic       s_reset = 1'b0, s_valid = 1'b0, s_sof = 1'b0, s_eof = 1'b0, s_ack = 1'b0;
  logic [7:0] s_data = 8'd0;
  always @(posedge clock) begin
    s_reset <= reset;
    s_valid <= pixValid;
    s_sof   <= pixSof;
    s_eof   <= pixEof;
    s_data  <= pixData;
    s_ack   <= detAck;
  end

  // Reference model: what each output must be after an edge, from the
  // frame-level rules. 'loading' = inside a frame, 'held' = complete frame
  // resident until acknowledged, 'idx' = linear position of the next pixel.
  bit m_seen = 0, m_ready = 0, m_wren = 0, m_show = 0, m_fr = 0;
  bit m_es = 0, m_ey = 0, m_el = 0, m_loading = 0, m_held = 0;
  int m_addr = 0, m_data = 0, m_fc = 0, m_idx = 0;

  always @(negedge clock) begin
    bit acc;
    if (s_reset) begin
      m_seen = 1; m_ready = 0; m_wren = 0; m_show = 1; m_addr = 0; m_data = 0;
      m_fr = 0; m_fc = 0; m_es = 0; m_ey = 0; m_el = 0;
      m_loading = 0; m_held = 0; m_idx = 0;
    end else begin
      acc = s_valid && m_ready;
      m_wren = 0;
      m_show = 0;
      if (m_held) begin
        if (!m_fr) begin
          m_fr = 1;
          m_fc = (m_fc + 1) % 256;
        end else if (s_ack) begin
          m_fr = 0;
          m_held = 0;
        end
      end else if (acc) begin
        if (s_sof) begin
          if (m_loading) m_ey = 1;
          m_loading = 1;
          m_idx = 0;
        end
        if (m_loading) begin
          m_wren = 1; m_show = 1; m_addr = m_idx; m_data = int'(s_data);
          if (m_idx == NPIX - 1) begin
            if (!s_eof) m_el = 1;
            m_held = 1;
            m_loading = 0;
          end else if (s_eof) begin
            m_es = 1;
            m_loading = 0;
          end else begin
            m_idx++;
          end
        end
      end
      m_ready = !m_held;
    end

    if (m_seen) begin
      chk("pixReady", pixReady, m_ready);
      chk("sramWren", sramWren, m_wren);
      chk("frameReady", frameReady, m_fr);
      chk("frameCount", frameCount, m_fc);
      chk("errShort", errShort, m_es);
      chk("errSync", errSync, m_ey);
      chk("errLong", errLong, m_el);
      if (m_show) begin
        chk("sramAddr", sramAddr, m_addr);
        chk("sramData", sramData, m_data);
      end
    end
    if (sramWren) wcnt++;
  end

  // Drive n accepted beats; sof_a/sof_b mark SOF positions, eof_at the EOF
  // position (-1 = none), rst_at aborts with a reset pulse on that beat.
  task automatic send_frame(input int n, input int sof_a, input int sof_b, input int eof_at,
                            input int gap_pct, input int rst_at, input bit rnd);
    int i = 0;
    int guard = 0;
    logic rdy;
    while (i < n) begin
      @(negedge clock);
      detAck = 1'b0;
      if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
        pixValid = 1'b0; pixSof = 1'b0; pixEof = 1'b0;
      end else begin
        pixValid = 1'b1;
        pixData  = rnd ? 8'($urandom) : 8'(i);
        pixSof   = (i == sof_a) || (i == sof_b);
        pixEof   = (i == eof_at);
      end
      if (i == rst_at) begin
        reset = 1'b1;
        pixValid = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        pixValid = 1'b0; pixSof = 1'b0; pixEof = 1'b0;
        return;
      end
      rdy = pixReady;
      if (pixValid && rdy) i++;
      guard++;
      if (guard > 4 * n + 100) begin
        chk("send_timeout", i, n);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      pixValid = 1'b0; pixSof = 1'b0; pixEof = 1'b0; detAck = 1'b0;
    end
  endtask

  // Wait for the held frame, pin its count, then acknowledge it.
  task automatic wait_ack(input int exp_fc);
    int t = 0;
    idle(1);
    while (!frameReady && t < 20) begin
      idle(1);
      t++;
    end
    chk("frameReady_seen", frameReady, 1);
    chk("frameCount_lit", frameCount, exp_fc);
    chk("pixReady_held", pixReady, 0);
    @(negedge clock);
    detAck = 1'b1;
    @(negedge clock);
    detAck = 1'b0;
    chk("frameReady_after_ack", frameReady, 0);
    chk("pixReady_after_ack", pixReady, 1);
    idle(2);
  endtask

  int w0;

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_pixReady", pixReady, 0);
    chk("rst_sramWren", sramWren, 0);
    chk("rst_sramAddr", sramAddr, 0);
    chk("rst_frameCount", frameCount, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", pixReady, 1);

    // Clean full frame, no gaps, data = index.
    w0 = wcnt;
    send_frame(NPIX, 0, -1, NPIX - 1, 0, -1, 0);
    wait_ack(1);
    chk("writes_full", wcnt - w0, NPIX);
    chk("no_err_short", errShort, 0);

    // Full frame with ~30% idle cycles and random data.
    w0 = wcnt;
    send_frame(NPIX, 0, -1, NPIX - 1, 30, -1, 1);
    wait_ack(2);
    chk("writes_gappy", wcnt - w0, NPIX);

    // Early EOF at pixel 99, then a clean frame.
    w0 = wcnt;
    send_frame(100, 0, -1, 99, 0, -1, 0);
    idle(4);
    chk("writes_short", wcnt - w0, 100);
    chk("errShort_set", errShort, 1);
    chk("short_no_frameReady", frameReady, 0);
    chk("short_frameCount", frameCount, 2);
    send_frame(NPIX, 0, -1, NPIX - 1, 0, -1, 1);
    wait_ack(3);

    // Second SOF at beat 500 restarts the frame.
    w0 = wcnt;
    send_frame(500 + NPIX, 0, 500, 500 + NPIX - 1, 10, -1, 1);
    wait_ack(4);
    chk("errSync_set", errSync, 1);
    chk("writes_resync", wcnt - w0, 500 + NPIX);

    // Leading junk without SOF, then a frame lacking EOF.
    w0 = wcnt;
    send_frame(10, -1, -1, -1, 0, -1, 0);
    idle(3);
    chk("writes_junk", wcnt - w0, 0);
    send_frame(NPIX, 0, -1, -1, 0, -1, 0);
    idle(2);
    chk("errLong_set", errLong, 1);
    wait_ack(5);

    // Reset mid-frame at beat 2000, then a clean frame from address 0.
    send_frame(NPIX, 0, -1, NPIX - 1, 0, 2000, 0);
    chk("midrst_sramWren", sramWren, 0);
    chk("midrst_pixReady", pixReady, 0);
    chk("midrst_frameCount", frameCount, 0);
    chk("midrst_errs", {errShort, errSync, errLong}, 0);
    w0 = wcnt;
    send_frame(NPIX, 0, -1, NPIX - 1, 20, -1, 1);
    wait_ack(1);
    chk("writes_after_rst", wcnt - w0, NPIX);

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
